// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and line alignment.
package mem_bus_pkg;

  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SNOOP = 3'd2,
    S_EVICT = 3'd3,
    S_READ  = 3'd4,
    S_WAIT  = 3'd5,
    S_FILL  = 3'd6
  } state_t;

  // Clears the byte offset so every memory access is line-aligned.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    line_align = {addr[63:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of cache-side, snoop and memory-side signals around the bus arbiter.
interface mem_bus_arbiter_if #(
  parameter int NUM_CACHES = 2,
  parameter int LINE_W     = 128,
  parameter int ADDR_W     = 32
);
  logic [NUM_CACHES-1:0]        req_valid;
  logic [NUM_CACHES-1:0]        req_excl;
  logic [NUM_CACHES*ADDR_W-1:0] req_addr;
  logic [NUM_CACHES-1:0]        req_evict;
  logic [NUM_CACHES*ADDR_W-1:0] req_evict_addr;
  logic [NUM_CACHES*LINE_W-1:0] req_evict_data;
  logic [NUM_CACHES-1:0]        grant;
  logic [NUM_CACHES-1:0]        fill_valid;
  logic [LINE_W-1:0]            fill_data;
  logic                         fill_shared;
  logic [NUM_CACHES-1:0]        snoop_valid;
  logic                         snoop_invl;
  logic [ADDR_W-1:0]            snoop_addr;
  logic [NUM_CACHES-1:0]        snoop_hit;
  logic [NUM_CACHES*LINE_W-1:0] snoop_data;
  logic [ADDR_W-1:0]            mem_addr;
  logic [LINE_W-1:0]            mem_wdata;
  logic                         mem_wren;
  logic                         mem_rden;
  logic [LINE_W-1:0]            mem_rdata;
  logic                         mem_rdata_valid;

  // Arbiter side.
  modport master (
    input  req_valid, req_excl, req_addr, req_evict, req_evict_addr, req_evict_data,
    input  snoop_hit, snoop_data, mem_rdata, mem_rdata_valid,
    output grant, fill_valid, fill_data, fill_shared, snoop_valid, snoop_invl, snoop_addr,
    output mem_addr, mem_wdata, mem_wren, mem_rden
  );

  // Caches and memory side.
  modport slave (
    output req_valid, req_excl, req_addr, req_evict, req_evict_addr, req_evict_data,
    output snoop_hit, snoop_data, mem_rdata, mem_rdata_valid,
    input  grant, fill_valid, fill_data, fill_shared, snoop_valid, snoop_invl, snoop_addr,
    input  mem_addr, mem_wdata, mem_wren, mem_rden
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int pos;
    pos    = 0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of a shared line-wide memory port: snoop, optional victim write, read, fill.
// Optional feature macro ARB_SNOOP_FWD_EN: a peer snoop hit supplies the fill line instead of memory.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_CACHES = 2,
  parameter int LINE_W     = 128,
  parameter int ADDR_W     = 32
) (
  input  logic clk,
  input  logic reset,
  mem_bus_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_CACHES);

  state_t                  state, state_next;
  logic [IDX_W-1:0]        rr_ptr, owner;
  logic [NUM_CACHES-1:0]   owner_oh, peer_hit;
  logic [NUM_CACHES-1:0]   pick_onehot;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_found;
  logic                    excl, evict, shared, fwd_hit;
  logic [ADDR_W-1:0]       miss_addr, evict_addr;
  logic [LINE_W-1:0]       evict_data, line_data, fwd_data;

  rr_picker #(.N(NUM_CACHES)) u_picker (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign owner_oh = {{(NUM_CACHES-1){1'b0}}, 1'b1} << owner;
  assign peer_hit = bus.snoop_hit & ~owner_oh;

`ifdef ARB_SNOOP_FWD_EN
  logic fwd;
  logic unused_pick_onehot;
  assign unused_pick_onehot = ^pick_onehot;
  assign fwd_hit = |peer_hit;

  // Scan downward so the lowest-index hitting peer wins.
  always_comb begin
    fwd_data = '0;
    for (int i = NUM_CACHES - 1; i >= 0; i--) begin
      if (peer_hit[i]) fwd_data = bus.snoop_data[i*LINE_W +: LINE_W];
    end
  end
`else
  logic fwd;
  logic unused_snoop_data;
  assign unused_snoop_data = ^{bus.snoop_data, pick_onehot};
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      owner  <= '0;
      excl   <= 1'b0;
      evict  <= 1'b0;
      shared <= 1'b0;
      fwd    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (pick_found) begin
          owner <= pick_idx;
          excl  <= bus.req_excl[pick_idx];
          evict <= bus.req_evict[pick_idx];
        end
        S_SNOOP: begin
          shared <= |peer_hit;
          fwd    <= fwd_hit;
        end
        S_FILL: rr_ptr <= (owner == IDX_W'(NUM_CACHES - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; they are only observed in states that load them first.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && pick_found) begin
      miss_addr  <= ADDR_W'(line_align(64'(bus.req_addr[pick_idx*ADDR_W +: ADDR_W])));
      evict_addr <= ADDR_W'(line_align(64'(bus.req_evict_addr[pick_idx*ADDR_W +: ADDR_W])));
      evict_data <= bus.req_evict_data[pick_idx*LINE_W +: LINE_W];
    end
    if (state == S_SNOOP && fwd_hit) line_data <= fwd_data;
    if (state == S_WAIT && bus.mem_rdata_valid) line_data <= bus.mem_rdata;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pick_found) state_next = S_GRANT;
      S_GRANT: state_next = S_SNOOP;
      S_SNOOP: state_next = evict ? S_EVICT : (fwd_hit ? S_FILL : S_READ);
      S_EVICT: state_next = fwd ? S_FILL : S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  if (bus.mem_rdata_valid) state_next = S_FILL;
      S_FILL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.grant       = '0;
    bus.fill_valid  = '0;
    bus.fill_data   = '0;
    bus.fill_shared = 1'b0;
    bus.snoop_valid = '0;
    bus.snoop_invl  = 1'b0;
    bus.snoop_addr  = '0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wren    = 1'b0;
    bus.mem_rden    = 1'b0;
    if (state != S_IDLE) bus.grant = owner_oh;
    case (state)
      S_SNOOP: begin
        bus.snoop_valid = ~owner_oh;
        bus.snoop_addr  = miss_addr;
        bus.snoop_invl  = excl;
      end
      S_EVICT: begin
        bus.mem_wren  = 1'b1;
        bus.mem_addr  = evict_addr;
        bus.mem_wdata = evict_data;
      end
      S_READ: begin
        bus.mem_rden = 1'b1;
        bus.mem_addr = miss_addr;
      end
      S_FILL: begin
        bus.fill_valid  = owner_oh;
        bus.fill_data   = line_data;
        // A forwarded line always has a peer copy, so only exclusivity decides the state.
        bus.fill_shared = fwd ? ~excl : (shared & ~excl);
      end
      default: ;
    endcase
  end

endmodule
